// File: rtl/temporizador.sv
// BCD mm:ss countdown timer driven by a TICK_DIV prescaler; optional "+30 s"
// strobe enabled by defining TEMPORIZADOR_MAIS30_EN.
module temporizador #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ligar,
  input  logic       clrn,
  input  logic       load,
  input  logic [3:0] digito,
`ifdef TEMPORIZADOR_MAIS30_EN
  input  logic       mais30,
`endif
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic       zero,
  output logic       fim
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc, presc_n;
  logic [3:0] md_n, mu_n, sd_n, su_n;
  logic [3:0] dmd, dmu, dsd, dsu;
  logic       b1, b2, b3;
  logic       run, tick, entry, fim_n;

  assign zero  = (min_dez == 4'd0) && (min_uni == 4'd0) &&
                 (seg_dez == 4'd0) && (seg_uni == 4'd0);
  assign run   = ligar && !zero;
  assign tick  = run && (presc == PW'(TICK_DIV - 1));
  assign entry = load && !ligar && (digito <= 4'd9);

  // Borrow-chain decrement; only used when the time is nonzero.
  always_comb begin
    b1  = (seg_uni == 4'd0);
    dsu = b1 ? 4'd9 : seg_uni - 4'd1;
    b2  = b1 && (seg_dez == 4'd0);
    dsd = b1 ? (b2 ? 4'd5 : seg_dez - 4'd1) : seg_dez;
    b3  = b2 && (min_uni == 4'd0);
    dmu = b2 ? (b3 ? 4'd9 : min_uni - 4'd1) : min_uni;
    dmd = b3 ? min_dez - 4'd1 : min_dez;
  end

`ifdef TEMPORIZADOR_MAIS30_EN
  logic [3:0] amd, amu, asd;
  logic [4:0] s3, m1, d1;
  logic [1:0] c1;
  logic       c2, sat;

  // Seconds tens may hold a keyed 6..9, so the +3 can carry one or two minutes.
  always_comb begin
    s3 = {1'b0, seg_dez} + 5'd3;
    if (s3 >= 5'd12) begin
      asd = 4'(s3 - 5'd12);
      c1  = 2'd2;
    end else if (s3 >= 5'd6) begin
      asd = 4'(s3 - 5'd6);
      c1  = 2'd1;
    end else begin
      asd = s3[3:0];
      c1  = 2'd0;
    end
    m1  = {1'b0, min_uni} + {3'd0, c1};
    c2  = (m1 >= 5'd10);
    amu = c2 ? 4'(m1 - 5'd10) : m1[3:0];
    d1  = {1'b0, min_dez} + {4'd0, c2};
    sat = (d1 >= 5'd10);
    amd = d1[3:0];
  end
`endif

  always_comb begin
    md_n  = min_dez;
    mu_n  = min_uni;
    sd_n  = seg_dez;
    su_n  = seg_uni;
    fim_n = 1'b0;
    if (!clrn) begin
      md_n = 4'd0;
      mu_n = 4'd0;
      sd_n = 4'd0;
      su_n = 4'd0;
    end else if (entry) begin
      md_n = min_uni;
      mu_n = seg_dez;
      sd_n = seg_uni;
      su_n = digito;
`ifdef TEMPORIZADOR_MAIS30_EN
    end else if (mais30) begin
      if (sat) begin
        md_n = 4'd9;
        mu_n = 4'd9;
        sd_n = 4'd5;
        su_n = 4'd9;
      end else begin
        md_n = amd;
        mu_n = amu;
        sd_n = asd;
        su_n = seg_uni;
      end
`endif
    end else if (tick) begin
      md_n  = dmd;
      mu_n  = dmu;
      sd_n  = dsd;
      su_n  = dsu;
      fim_n = (dmd == 4'd0) && (dmu == 4'd0) && (dsd == 4'd0) && (dsu == 4'd0);
    end
  end

  // A pause or an empty display restarts a full second.
  always_comb begin
    if (!clrn || !run || tick) presc_n = '0;
    else                       presc_n = presc + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_dez <= 4'd0;
      min_uni <= 4'd0;
      seg_dez <= 4'd0;
      seg_uni <= 4'd0;
      presc   <= '0;
      fim     <= 1'b0;
    end else begin
      min_dez <= md_n;
      min_uni <= mu_n;
      seg_dez <= sd_n;
      seg_uni <= su_n;
      presc   <= presc_n;
      fim     <= fim_n;
    end
  end

endmodule

// File: tb/tb_temporizador.sv
// Randomized bench for temporizador against a digit/seconds reference model;
// define TEMPORIZADOR_MAIS30_EN to also exercise the +30 s strobe.
module tb_temporizador;

  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst, ligar, clrn, load, mais30;
  logic [3:0] digito;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic zero, fim;

  int total = 0;
  int bad = 0;
  int fimSeen = 0;
  int md, mu, sd, su, cnt, mfim;

  temporizador #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .ligar(ligar), .clrn(clrn), .load(load),
    .digito(digito),
`ifdef TEMPORIZADOR_MAIS30_EN
    .mais30(mais30),
`endif
    .min_dez(min_dez), .min_uni(min_uni), .seg_dez(seg_dez),
    .seg_uni(seg_uni), .zero(zero), .fim(fim)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelTime();
    return (md << 12) | (mu << 8) | (sd << 4) | su;
  endfunction

  task automatic modelReset();
    md = 0; mu = 0; sd = 0; su = 0; cnt = 0; mfim = 0;
  endtask

  // Next model state from the rules: priority clear, entry, +30, tick.
  task automatic modelStep(input logic l, input logic c, input logic ld,
                           input logic [3:0] d, input logic m);
    int tot;
    bit run, tick;
    run  = l && (modelTime() != 0);
    tick = run && (cnt == TICK_DIV - 1);
    mfim = 0;
    if (!c) begin
      md = 0; mu = 0; sd = 0; su = 0;
    end else if (ld && !l && d <= 9) begin
      md = mu; mu = sd; sd = su; su = int'(d);
    end else if (m) begin
      tot = md * 600 + mu * 60 + sd * 10 + su + 30;
      if (tot > 5999) tot = 5999;
      md = tot / 600;
      mu = (tot % 600) / 60;
      sd = (tot % 60) / 10;
      su = tot % 10;
    end else if (tick) begin
      if (su > 0) su--;
      else if (sd > 0) begin sd--; su = 9; end
      else if (mu > 0) begin mu--; sd = 5; su = 9; end
      else begin md--; mu = 9; sd = 5; su = 9; end
      if (modelTime() == 0) mfim = 1;
    end
    cnt = (!c || !run || tick) ? 0 : cnt + 1;
  endtask

  task automatic applyStimulus(input logic l, input logic c, input logic ld,
                               input logic [3:0] d, input logic m);
    ligar = l; clrn = c; load = ld; digito = d; mais30 = m;
    @(posedge clk);
    modelStep(l, c, ld, d, m);
    #1;
    checkOutput("digits", {min_dez, min_uni, seg_dez, seg_uni}, modelTime());
    checkOutput("zero", zero, modelTime() == 0);
    checkOutput("fim", fim, mfim);
    if (fim) fimSeen++;
  endtask

  task automatic loadTime(input logic [15:0] t);
    logic [15:0] v;
    v = t;
    for (int i = 3; i >= 0; i--) applyStimulus(1'b0, 1'b1, 1'b1, v[i*4 +: 4], 1'b0);
  endtask

  task automatic idle(input logic l, input int n);
    for (int i = 0; i < n; i++) applyStimulus(l, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    logic l, c, ld, m;
    logic [3:0] d;
    rst = 1'b1; ligar = 1'b0; clrn = 1'b1; load = 1'b0; digito = 4'd0; mais30 = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_digits", {min_dez, min_uni, seg_dez, seg_uni}, 0);
    checkOutput("reset_zero", zero, 1);
    checkOutput("reset_fim", fim, 0);
    rst = 1'b0;

    // Entry, invalid digit ignored, load ignored while running
    loadTime(16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hA, 1'b0);
    checkOutput("entry_1234", {min_dez, min_uni, seg_dez, seg_uni}, 16'h1234);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
    checkOutput("load_running", {min_dez, min_uni, seg_dez, seg_uni}, 16'h1234);
    idle(1'b0, 1);

    // Countdown 01:00 to 00:00
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(1'b0, 1);
    loadTime(16'h0100);
    fimSeen = 0;
    idle(1'b1, 4);
    checkOutput("first_dec", {min_dez, min_uni, seg_dez, seg_uni}, 16'h0059);
    idle(1'b1, 236);
    checkOutput("end_fim", fim, 1);
    checkOutput("end_zero", zero, 1);
    idle(1'b1, 10);
    checkOutput("fim_once", fimSeen, 1);
    checkOutput("stay_zero", {min_dez, min_uni, seg_dez, seg_uni}, 0);

    // Pause mid-second
    idle(1'b0, 1);
    loadTime(16'h0010);
    idle(1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput("pause_hold", {min_dez, min_uni, seg_dez, seg_uni}, 16'h0010);
    end
    idle(1'b1, 3);
    checkOutput("pause_restart", {min_dez, min_uni, seg_dez, seg_uni}, 16'h0010);
    idle(1'b1, 1);
    checkOutput("pause_dec", {min_dez, min_uni, seg_dez, seg_uni}, 16'h0009);

    // Clear while running
    idle(1'b0, 1);
    loadTime(16'h0500);
    idle(1'b1, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("clear_run", {min_dez, min_uni, seg_dez, seg_uni}, 0);
    checkOutput("clear_fim", fim, 0);

    // Asynchronous reset mid-count
    idle(1'b0, 1);
    loadTime(16'h0030);
    idle(1'b1, 5);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst", {min_dez, min_uni, seg_dez, seg_uni}, 0);
    checkOutput("async_zero", zero, 1);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

`ifdef TEMPORIZADOR_MAIS30_EN
    idle(1'b0, 1);
    loadTime(16'h0045);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("add_0045", {min_dez, min_uni, seg_dez, seg_uni}, 16'h0115);
    loadTime(16'h9945);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("add_sat", {min_dez, min_uni, seg_dez, seg_uni}, 16'h9959);
    loadTime(16'h0010);
    idle(1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("add_tick", {min_dez, min_uni, seg_dez, seg_uni}, 16'h0040);
    idle(1'b0, 1);
`endif

    // Randomized traffic
    l = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) l = ~l;
      c  = ($urandom_range(0, 49) != 0);
      ld = ($urandom_range(0, 6) == 0);
      d  = 4'($urandom_range(0, 15));
`ifdef TEMPORIZADOR_MAIS30_EN
      m  = ($urandom_range(0, 19) == 0);
`else
      m  = 1'b0;
`endif
      applyStimulus(l, c, ld, d, m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
